reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- Parametrised integer register file for the core: NREG registers of XLEN bits, two combinational read ports and one write port.
- Register 0 is hardwired to zero.
- After reset, a built-in clear sequencer zeroes the array one entry per cycle, so the storage can map to RAM-style cells; busy is high until the clear completes.
- Sits between decode (read addresses) and writeback (write port).

Parameters:
- XLEN, 32, data width; taken from core_general.vh.
- NREG, 32, number of registers; 32 for RV32I, 16 for RV32E.
- AW, 5, address width; must be >= clog2(NREG).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- we  in  1  write enable.
- waddr  in  AW  write address.
- wdata  in  XLEN  write data.
- raddr1  in  AW  read port 1 address.
- rdata1  out  XLEN  read port 1 data (combinational).
- raddr2  in  AW  read port 2 address.
- rdata2  out  XLEN  read port 2 data (combinational).
- busy  out  1  high while the clear sequence runs.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named rst.
- FSM states: CLEAR and READY.
- rst=1 at a rising edge: state<=CLEAR, clear counter<=1, busy=1 on the following cycle.
  - Register contents are not reset directly; they are zeroed by the sequence below.
- CLEAR state:
  - Each cycle, writes 0 to entry[counter] and increments the counter.
  - When counter==NREG-1 is written, state<=READY.
  - Total duration is NREG-1 cycles after rst deasserts (31 cycles for NREG=32).
  - we is ignored.
  - rdata1/rdata2 read as 0 regardless of address.
- READY state:
  - busy=0.
  - we=1 with waddr in 1..NREG-1: entry[waddr]<=wdata at the rising edge. The new value is visible on read ports from the next cycle.
- Address 0:
  - Reads always return 0.
  - Writes to address 0 are discarded.
- Out-of-range addresses (>= NREG, possible when NREG < 2^AW):
  - Reads return 0.
  - Writes are discarded. No aliasing or wrap.
- Same-cycle read and write to the same address: the read returns the old value (unless REGFILE_BYPASS_EN is defined).
- Both read ports may address the same register; each returns the identical value.
- rst asserted mid-CLEAR: the counter restarts at 1 and the full sequence reruns.
- rst asserted in READY: the clear reruns and all prior contents are lost.
- Outputs while rst=1: busy=1, rdata1=rdata2=0.
- Widths: all data paths are XLEN bits with no truncation. The counter is AW bits and never exceeds NREG-1.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: in READY, when we=1, waddr!=0, waddr<NREG and raddrN==waddr, rdataN=wdata in the same cycle (write-through forwarding). Removes one writeback hazard stall.
- Not defined: a same-cycle read returns the stored (old) value.
- In CLEAR, reads return 0 either way.

Decomposition:
- core_general.vh holds XLEN, the default NREG, and the derived AW constant.
- Sub-module reg_file_clr holds the FSM and counter.
  - Outputs: busy, clr_we, clr_addr.
  - The array muxes its write port between the sequencer and the external write.

Test Plan:
- Reset clear: hold rst=1 for 2 cycles, release -> busy=1 for exactly 31 cycles (NREG=32), then 0. Every address 0..31 reads 0.
- Basic write/read:
  - we=1, waddr=5, wdata=32'haaaaaaaa, then read raddr1=5 -> 32'haaaaaaaa.
  - Then write waddr=5, wdata=32'h55555555, and read on both ports -> 32'h55555555.
- x0 and out-of-range:
  - Write waddr=0, wdata=32'hffffffff -> read 0 returns 0.
  - With NREG=16, write waddr=20 -> no entry changes; raddr=20 returns 0; raddr=4 is unchanged.
- Same-cycle hazard: entry 7 holds 32'h00000000; write waddr=7, wdata=32'h12345678 with raddr2=7 in the same cycle -> rdata2=0 without the macro, 32'h12345678 with it; 32'h12345678 in both cases on the next cycle.
- Ignored during clear: we=1, waddr=3, wdata=32'hdeadbeef while busy=1 -> entry 3 reads 0 after busy falls.
- Reset mid-clear: assert rst for 1 cycle at clear cycle 10 -> busy stays high for a full 31 cycles after release, and all entries read 0.

Source files
------------

// File: rtl/reg_file_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_pkg
//   Shared constants and types for the integer register file.
//   - XLEN_DEF / NREG_DEF / AW_DEF : default data width, register count and
//     address width (AW_DEF derived from NREG_DEF).
//   - clr_state_t                  : clear-sequencer FSM states.
//   - addr_writable()              : true for an architectural, non-x0 address.
// -----------------------------------------------------------------------------
package reg_file_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int AW_DEF   = $clog2(NREG_DEF);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } clr_state_t;

    // Address 0 is the hardwired zero register and addresses at or above nreg
    // do not exist; neither may be read from storage or written.
    function automatic logic addr_writable(input int addr, input int nreg);
        return (addr != 0) && (addr < nreg);
    endfunction

endpackage

// File: rtl/reg_file_clr.sv
// -----------------------------------------------------------------------------
// reg_file_clr
//   Post-reset clear sequencer for reg_file. After rst it walks a counter from
//   1 to NREG-1, requesting a zero write to each entry, then parks in READY.
//   Entry 0 is never written because reads of x0 are forced to zero anyway.
//
//   Ports:
//     clk       in   core clock
//     rst       in   synchronous, active-high reset
//     busy      out  high while rst is asserted or the clear is running
//     clr_we    out  sequencer write request (zero data) for this cycle
//     clr_addr  out  entry addressed by the sequencer write
// -----------------------------------------------------------------------------
module reg_file_clr
    import reg_file_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int AW   = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    clr_state_t    r_state;
    clr_state_t    w_state_nxt;
    logic [AW-1:0] r_cnt;
    logic [AW-1:0] w_cnt_nxt;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order between processes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_CLEAR;
            r_cnt   <= AW'(1);
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // NOTE: defaults come first so every path assigns every output; a missing
    // assignment in any branch would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_CLEAR: begin
                // The last entry is written this cycle; hold the counter at
                // NREG-1 rather than letting it run past the array.
                if (r_cnt == AW'(NREG - 1)) begin
                    w_state_nxt = ST_READY;
                end else begin
                    w_cnt_nxt = r_cnt + AW'(1);
                end
            end
            ST_READY: begin
                w_state_nxt = ST_READY;
            end
            default: begin
                w_state_nxt = ST_CLEAR;
                w_cnt_nxt   = AW'(1);
            end
        endcase
    end

    // busy covers the reset cycles themselves so consumers stall immediately.
    assign busy     = rst || (r_state == ST_CLEAR);
    assign clr_we   = !rst && (r_state == ST_CLEAR);
    assign clr_addr = r_cnt;

endmodule

// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file
//   Integer register file: NREG x XLEN storage, two combinational read ports,
//   one synchronous write port. x0 reads as zero and ignores writes; addresses
//   >= NREG read as zero and ignore writes (no aliasing). After reset a clear
//   sequencer zeroes entries 1..NREG-1 one per cycle; while busy, external
//   writes are dropped and both read ports return zero.
//
//   Build option:
//     REGFILE_BYPASS_EN - when defined, a read port whose address matches an
//                         accepted same-cycle write returns the write data.
//                         When undefined, the read returns the stored value.
//
//   Ports:
//     clk     in   core clock
//     rst     in   synchronous, active-high reset
//     we      in   write enable
//     waddr   in   write address
//     wdata   in   write data
//     raddr1  in   read port 1 address
//     rdata1  out  read port 1 data (combinational)
//     raddr2  in   read port 2 address
//     rdata2  out  read port 2 data (combinational)
//     busy    out  high while the clear sequence runs
// -----------------------------------------------------------------------------
module reg_file
    import reg_file_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int AW   = AW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr1,
    output logic [XLEN-1:0] rdata1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata2,
    output logic            busy
);

    // Index width of the storage array; addresses are range-checked first, so
    // only the low IW bits are needed to select an entry.
    localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;

    logic            w_busy;
    logic            w_clr_we;
    logic [AW-1:0]   w_clr_addr;
    logic            w_ext_we;
    logic            w_mem_we;
    logic [IW-1:0]   w_mem_idx;
    logic [XLEN-1:0] w_mem_data;
    logic [XLEN-1:0] r_mem [NREG];

    reg_file_clr #(
        .NREG (NREG),
        .AW   (AW)
    ) u_clr (
        .clk      (clk),
        .rst      (rst),
        .busy     (w_busy),
        .clr_we   (w_clr_we),
        .clr_addr (w_clr_addr)
    );

    // External writes are accepted only in READY and only to real, non-x0
    // entries; everything else is dropped here.
    assign w_ext_we = !w_busy && we && addr_writable(32'(waddr), NREG);

    // Single physical write port shared by the sequencer and writeback. The
    // two never collide because w_ext_we is gated off while busy.
    assign w_mem_we   = w_clr_we || w_ext_we;
    assign w_mem_idx  = w_clr_we ? w_clr_addr[IW-1:0] : waddr[IW-1:0];
    assign w_mem_data = w_clr_we ? '0 : wdata;

    // NOTE: the array has no reset term, so it can map onto RAM cells; the
    // clear sequencer is what brings it to a known state.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_idx] <= w_mem_data;
        end
    end

    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (!w_busy) begin
            if (addr_writable(32'(raddr1), NREG)) begin
                rdata1 = r_mem[raddr1[IW-1:0]];
`ifdef REGFILE_BYPASS_EN
                // Forward the in-flight writeback value to its reader.
                if (w_ext_we && (raddr1 == waddr)) begin
                    rdata1 = wdata;
                end
`endif
            end
            if (addr_writable(32'(raddr2), NREG)) begin
                rdata2 = r_mem[raddr2[IW-1:0]];
`ifdef REGFILE_BYPASS_EN
                if (w_ext_we && (raddr2 == waddr)) begin
                    rdata2 = wdata;
                end
`endif
            end
        end
    end

    assign busy = w_busy;

endmodule

// File: tb/tb_reg_file.sv
// -----------------------------------------------------------------------------
// tb_reg_file
//   Directed bench for reg_file. Two instances share clk and rst:
//     u_dut32 : default build (NREG=32, AW=5)
//     u_dut16 : NREG=16 with AW=5, so addresses 16..31 are out of range.
//   Inputs change 1 ns after a rising edge; outputs are sampled before the
//   next edge.
// -----------------------------------------------------------------------------
module tb_reg_file;

    localparam int XLEN = 32;
    localparam int AW   = 5;

`ifdef REGFILE_BYPASS_EN
    localparam logic [XLEN-1:0] HAZ_EXP = 32'h12345678;
`else
    localparam logic [XLEN-1:0] HAZ_EXP = 32'h00000000;
`endif

    logic            clk = 1'b0;
    logic            rst;

    logic            we;
    logic [AW-1:0]   waddr;
    logic [XLEN-1:0] wdata;
    logic [AW-1:0]   raddr1;
    logic [AW-1:0]   raddr2;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
    logic            busy;

    logic            s_we;
    logic [AW-1:0]   s_waddr;
    logic [XLEN-1:0] s_wdata;
    logic [AW-1:0]   s_raddr1;
    logic [AW-1:0]   s_raddr2;
    logic [XLEN-1:0] s_rdata1;
    logic [XLEN-1:0] s_rdata2;
    logic            s_busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    reg_file u_dut32 (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .raddr1 (raddr1),
        .rdata1 (rdata1),
        .raddr2 (raddr2),
        .rdata2 (rdata2),
        .busy   (busy)
    );

    reg_file #(
        .XLEN (XLEN),
        .NREG (16),
        .AW   (AW)
    ) u_dut16 (
        .clk    (clk),
        .rst    (rst),
        .we     (s_we),
        .waddr  (s_waddr),
        .wdata  (s_wdata),
        .raddr1 (s_raddr1),
        .rdata1 (s_rdata1),
        .raddr2 (s_raddr2),
        .rdata2 (s_rdata2),
        .busy   (s_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts busy cycles of both instances from the current cycle until both
    // are idle, bounded by a cycle budget. If drive_we is set, the 32-entry
    // instance sees we=1 to entry 3 for the first 19 of those cycles.
    task automatic run_clear(input bit drive_we, output int n32, output int n16);
        n32 = 0;
        n16 = 0;
        for (int c = 0; c < 100; c++) begin
            if (!busy && !s_busy) break;
            if (busy)   n32++;
            if (s_busy) n16++;
            we    = drive_we && (c < 19);
            waddr = 5'd3;
            wdata = 32'hdeadbeef;
            tick();
        end
        we = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 32; i++) begin
            raddr1   = AW'(i);
            raddr2   = AW'(31 - i);
            s_raddr1 = AW'(i);
            s_raddr2 = AW'(31 - i);
            #1;
            n_checks++;
            if (rdata1 !== '0) begin
                n_fail++;
                $display("FAIL %s rd1[%0d]: got %h want 00000000", tag, i, rdata1);
            end
            n_checks++;
            if (rdata2 !== '0) begin
                n_fail++;
                $display("FAIL %s rd2[%0d]: got %h want 00000000", tag, 31 - i, rdata2);
            end
            n_checks++;
            if (s_rdata1 !== '0) begin
                n_fail++;
                $display("FAIL %s n16 rd1[%0d]: got %h want 00000000", tag, i, s_rdata1);
            end
            n_checks++;
            if (s_rdata2 !== '0) begin
                n_fail++;
                $display("FAIL %s n16 rd2[%0d]: got %h want 00000000", tag, 31 - i, s_rdata2);
            end
        end
    endtask

    task automatic test_reset();
        int n32;
        int n16;
        rst = 1'b1;
        we = 1'b0; waddr = '0; wdata = '0; raddr1 = 5'd5; raddr2 = 5'd0;
        s_we = 1'b0; s_waddr = '0; s_wdata = '0; s_raddr1 = 5'd5; s_raddr2 = 5'd0;
        tick();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset busy: got %b want 1", busy);
        end
        n_checks++;
        if (rdata1 !== '0 || rdata2 !== '0) begin
            n_fail++;
            $display("FAIL reset rdata: got %h/%h want 0/0", rdata1, rdata2);
        end
        tick();
        rst = 1'b0;
        // Writes to entry 3 during the clear must be ignored.
        run_clear(1'b1, n32, n16);
        n_checks++;
        if (n32 !== 31) begin
            n_fail++;
            $display("FAIL clear_len32: got %0d cycles want 31", n32);
        end
        n_checks++;
        if (n16 !== 15) begin
            n_fail++;
            $display("FAIL clear_len16: got %0d cycles want 15", n16);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_after_clear: got %b want 0", busy);
        end
        check_all_zero("clear");
    endtask

    task automatic test_ignored_during_clear();
        raddr1 = 5'd3;
        #1;
        n_checks++;
        if (rdata1 !== 32'h0) begin
            n_fail++;
            $display("FAIL we_ignored_busy: entry3 got %h want 00000000", rdata1);
        end
    endtask

    task automatic test_basic();
        we = 1'b1; waddr = 5'd5; wdata = 32'haaaaaaaa; raddr1 = 5'd5;
        tick();
        we = 1'b0;
        #1;
        n_checks++;
        if (rdata1 !== 32'haaaaaaaa) begin
            n_fail++;
            $display("FAIL basic_wr1: got %h want aaaaaaaa", rdata1);
        end
        we = 1'b1; waddr = 5'd5; wdata = 32'h55555555; raddr2 = 5'd5;
        tick();
        we = 1'b0;
        #1;
        n_checks++;
        if (rdata1 !== 32'h55555555 || rdata2 !== 32'h55555555) begin
            n_fail++;
            $display("FAIL basic_wr2: got %h/%h want 55555555/55555555", rdata1, rdata2);
        end
    endtask

    task automatic test_x0_and_range();
        we = 1'b1; waddr = 5'd0; wdata = 32'hffffffff;
        tick();
        we = 1'b0;
        raddr1 = 5'd0; raddr2 = 5'd0;
        #1;
        n_checks++;
        if (rdata1 !== '0 || rdata2 !== '0) begin
            n_fail++;
            $display("FAIL x0_write: got %h/%h want 0/0", rdata1, rdata2);
        end
        // Top in-range entry and first out-of-range entry on the 16-entry part.
        s_we = 1'b1; s_waddr = 5'd4; s_wdata = 32'h00004444;
        tick();
        s_waddr = 5'd15; s_wdata = 32'h0f0f0f0f;
        tick();
        s_waddr = 5'd20; s_wdata = 32'hffffffff;
        tick();
        s_waddr = 5'd16; s_wdata = 32'heeeeeeee;
        tick();
        s_we = 1'b0;
        s_raddr1 = 5'd20; s_raddr2 = 5'd4;
        #1;
        n_checks++;
        if (s_rdata1 !== '0) begin
            n_fail++;
            $display("FAIL oor_read20: got %h want 00000000", s_rdata1);
        end
        n_checks++;
        if (s_rdata2 !== 32'h00004444) begin
            n_fail++;
            $display("FAIL oor_alias4: got %h want 00004444", s_rdata2);
        end
        s_raddr1 = 5'd15; s_raddr2 = 5'd0;
        #1;
        n_checks++;
        if (s_rdata1 !== 32'h0f0f0f0f) begin
            n_fail++;
            $display("FAIL n16_top15: got %h want 0f0f0f0f", s_rdata1);
        end
        n_checks++;
        if (s_rdata2 !== '0) begin
            n_fail++;
            $display("FAIL n16_alias0: got %h want 00000000", s_rdata2);
        end
        s_raddr1 = 5'd16;
        #1;
        n_checks++;
        if (s_rdata1 !== '0) begin
            n_fail++;
            $display("FAIL oor_read16: got %h want 00000000", s_rdata1);
        end
    endtask

    task automatic test_hazard();
        we = 1'b1; waddr = 5'd7; wdata = 32'h12345678; raddr2 = 5'd7; raddr1 = 5'd5;
        #1;
        n_checks++;
        if (rdata2 !== HAZ_EXP) begin
            n_fail++;
            $display("FAIL hazard_same_cycle: got %h want %h", rdata2, HAZ_EXP);
        end
        n_checks++;
        if (rdata1 !== 32'h55555555) begin
            n_fail++;
            $display("FAIL hazard_other_port: got %h want 55555555", rdata1);
        end
        tick();
        we = 1'b0;
        #1;
        n_checks++;
        if (rdata2 !== 32'h12345678) begin
            n_fail++;
            $display("FAIL hazard_next_cycle: got %h want 12345678", rdata2);
        end
    endtask

    task automatic test_back_to_back();
        logic [XLEN-1:0] vals [3];
        vals[0] = 32'h0000000a;
        vals[1] = 32'h000000b0;
        vals[2] = 32'h00000c00;
        for (int i = 0; i < 3; i++) begin
            we = 1'b1; waddr = AW'(10 + i); wdata = vals[i];
            tick();
        end
        we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            raddr1 = AW'(10 + i);
            raddr2 = AW'(10 + i);
            #1;
            n_checks++;
            if (rdata1 !== vals[i] || rdata2 !== vals[i]) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got %h/%h want %h", 10 + i, rdata1, rdata2, vals[i]);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        int n32;
        int n16;
        // Reset from READY with live data, then again partway through the clear.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
        end
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_clear_busy: got %b want 1", busy);
        end
        rst = 1'b1;
        raddr1 = 5'd5;
        #1;
        n_checks++;
        if (busy !== 1'b1 || rdata1 !== '0) begin
            n_fail++;
            $display("FAIL rst_outputs: got busy=%b rd1=%h want busy=1 rd1=0", busy, rdata1);
        end
        tick();
        rst = 1'b0;
        run_clear(1'b0, n32, n16);
        n_checks++;
        if (n32 !== 31) begin
            n_fail++;
            $display("FAIL rerun_len32: got %0d cycles want 31", n32);
        end
        n_checks++;
        if (n16 !== 15) begin
            n_fail++;
            $display("FAIL rerun_len16: got %0d cycles want 15", n16);
        end
        check_all_zero("rerun");
    endtask

    initial begin
        test_reset();
        test_ignored_during_clear();
        test_basic();
        test_x0_and_range();
        test_hazard();
        test_back_to_back();
        test_reset_mid_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
